// File: rtl/pcs_scrambler_pkg.sv
// Shared constants for the 64b/66b self-synchronous scrambler (x^58 + x^39 + 1).
//   TAP0/TAP1 : state bits feeding bit 0 of a word (x[-39] -> s[38], x[-58] -> s[57])
//   S_W       : history length
//   SEED_RST  : state value after reset
//   MODE_*    : values for the DESCRAMBLE parameter
package pcs_scrambler_pkg;

  localparam int TAP0 = 38;
  localparam int TAP1 = 57;
  localparam int S_W  = 58;

  localparam logic [S_W-1:0] SEED_RST = {S_W{1'b1}};

  localparam int MODE_SCR   = 0;
  localparam int MODE_DESCR = 1;

endpackage

// File: rtl/pcs_scrambler_lane.sv
// One lane of the self-synchronous scrambler/descrambler.
// Ports:
//   clk, nreset         : clock, synchronous active-low reset
//   valid               : lane beat present; advances the history
//   bypass              : data_out = data_in, history frozen
//   seed_load, seed     : overwrite history with seed (highest priority after reset)
//   data_in / data_out  : LEN payload bits, bit 0 first on the line (data_out combinational)
module pcs_scrambler_lane
  import pcs_scrambler_pkg::*;
#(
  parameter int LEN        = 32,
  parameter int DESCRAMBLE = MODE_SCR
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           valid,
  input  logic           bypass,
  input  logic           seed_load,
  input  logic [S_W-1:0] seed,
  input  logic [LEN-1:0] data_in,
  output logic [LEN-1:0] data_out
);

  logic [S_W-1:0]     state;
  logic [S_W-1:0]     state_adv;
  logic [LEN-1:0]     res;
  // Line-ordered history: hist[k] for k < S_W is the old state, oldest first
  // (hist[k] = state[S_W-1-k]); hist[S_W+i] is the history bit x[i] of this word.
  // With this layout x[i-39] is hist[i+19] and x[i-58] is hist[i], for any LEN.
  logic [S_W+LEN-1:0] hist;

  always_comb begin
    hist      = '0;
    res       = '0;
    state_adv = state;
    for (int k = 0; k < S_W; k++) begin
      hist[k] = state[S_W-1-k];
    end
    for (int i = 0; i < LEN; i++) begin
      res[i] = data_in[i] ^ hist[i + S_W - 1 - TAP0] ^ hist[i + S_W - 1 - TAP1];
      // Scrambler feeds back its own output; descrambler keeps the line data.
      hist[S_W+i] = (DESCRAMBLE == MODE_DESCR) ? data_in[i] : res[i];
    end
    // New state is the newest S_W history bits, newest in bit 0. This covers
    // both LEN >= S_W and the shift-in case LEN < S_W.
    for (int i = 0; i < S_W; i++) begin
      state_adv[i] = hist[S_W+LEN-1-i];
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= SEED_RST;
    end else if (seed_load) begin
      state <= seed;
    end else if (valid && !bypass) begin
      state <= state_adv;
    end
  end

  assign data_out = bypass ? data_in : res;

endmodule

// File: rtl/pcs_scrambler_mlane.sv
// Multi-lane 64b/66b scrambler (DESCRAMBLE=0) or descrambler (DESCRAMBLE=1).
// Ports:
//   clk, nreset : clock, synchronous active-low reset
//   valid_i     : per-lane valid (LANE_N)
//   data_i      : lane k at [k*LEN +: LEN]
//   head_i      : per-lane 2-bit sync header, passed through unscrambled
//   bypass_i    : pass data unmodified, freeze all lane states
//   seed_load_i : load seed_i into every lane state
//   seed_i      : seed, bit 0 = most recent history bit
//   valid_o, data_o, head_o : registered outputs, one cycle latency;
//                 data_o/head_o lanes load only when that lane's valid_i is set
module pcs_scrambler_mlane
  import pcs_scrambler_pkg::*;
#(
  parameter int LANE_N     = 4,
  parameter int LEN        = 32,
  parameter int DESCRAMBLE = MODE_SCR
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [LANE_N-1:0]     valid_i,
  input  logic [LANE_N*LEN-1:0] data_i,
  input  logic [LANE_N*2-1:0]   head_i,
  input  logic                  bypass_i,
  input  logic                  seed_load_i,
  input  logic [S_W-1:0]        seed_i,
  output logic [LANE_N-1:0]     valid_o,
  output logic [LANE_N*LEN-1:0] data_o,
  output logic [LANE_N*2-1:0]   head_o
);

  logic [LANE_N*LEN-1:0] lane_out;

  for (genvar k = 0; k < LANE_N; k++) begin : g_lane
    pcs_scrambler_lane #(
      .LEN        (LEN),
      .DESCRAMBLE (DESCRAMBLE)
    ) u_lane (
      .clk       (clk),
      .nreset    (nreset),
      .valid     (valid_i[k]),
      .bypass    (bypass_i),
      .seed_load (seed_load_i),
      .seed      (seed_i),
      .data_in   (data_i[k*LEN +: LEN]),
      .data_out  (lane_out[k*LEN +: LEN])
    );
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      valid_o <= '0;
      data_o  <= '0;
      head_o  <= '0;
    end else begin
      valid_o <= valid_i;
      for (int k = 0; k < LANE_N; k++) begin
        if (valid_i[k]) begin
          data_o[k*LEN +: LEN] <= lane_out[k*LEN +: LEN];
          head_o[k*2 +: 2]     <= head_i[k*2 +: 2];
        end
      end
    end
  end

endmodule

// File: tb/tb_pcs_scrambler_mlane.sv
// Testbench for pcs_scrambler_mlane: a 4-lane LEN=32 scrambler checked against
// a bit-serial reference model (vector table + random traffic), and TX->RX
// chains for LEN 16/32/64/66 checked with a per-lane scoreboard.
module tb_pcs_scrambler_mlane;
  import pcs_scrambler_pkg::*;

  localparam int LN = 4;
  localparam int LW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              nreset;
  logic [LN-1:0]     valid_i, valid_o;
  logic [LN*LW-1:0]  data_i, data_o;
  logic [LN*2-1:0]   head_i, head_o;
  logic              bypass_i, seed_load_i;
  logic [S_W-1:0]    seed_i;

  pcs_scrambler_mlane #(.LANE_N(LN), .LEN(LW), .DESCRAMBLE(0)) u_dut (
    .clk         (clk),
    .nreset      (nreset),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .head_i      (head_i),
    .bypass_i    (bypass_i),
    .seed_load_i (seed_load_i),
    .seed_i      (seed_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .head_o      (head_o)
  );

  // TX -> RX chains
  localparam int CN = 4;
  localparam int CL [CN] = '{16, 32, 64, 66};

  logic [131:0] ch_data;
  logic [1:0]   ch_valid;
  logic [3:0]   ch_head;
  logic         ch_rx_sl;
  logic [131:0] ch_rx_data  [CN];
  logic [1:0]   ch_rx_valid [CN];
  logic [3:0]   ch_rx_head  [CN];

  for (genvar g = 0; g < CN; g++) begin : g_chain
    localparam int L = CL[g];
    logic [1:0]     tv, rv;
    logic [2*L-1:0] td, rd;
    logic [3:0]     th, rh;

    pcs_scrambler_mlane #(.LANE_N(2), .LEN(L), .DESCRAMBLE(0)) u_tx (
      .clk         (clk),
      .nreset      (nreset),
      .valid_i     (ch_valid),
      .data_i      (ch_data[2*L-1:0]),
      .head_i      (ch_head),
      .bypass_i    (1'b0),
      .seed_load_i (1'b0),
      .seed_i      ({S_W{1'b1}}),
      .valid_o     (tv),
      .data_o      (td),
      .head_o      (th)
    );

    pcs_scrambler_mlane #(.LANE_N(2), .LEN(L), .DESCRAMBLE(1)) u_rx (
      .clk         (clk),
      .nreset      (nreset),
      .valid_i     (tv),
      .data_i      (td),
      .head_i      (th),
      .bypass_i    (1'b0),
      .seed_load_i (ch_rx_sl),
      .seed_i      ({S_W{1'b0}}),
      .valid_o     (rv),
      .data_o      (rd),
      .head_o      (rh)
    );

    assign ch_rx_data[g]  = 132'(rd);
    assign ch_rx_valid[g] = rv;
    assign ch_rx_head[g]  = rh;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bit-serial reference: shift register with newest bit in [0]
  function automatic void scr_ref(input logic [57:0] s_in, input logic [LW-1:0] d,
                                  output logic [LW-1:0] r, output logic [57:0] s_out);
    logic [57:0] sr;
    sr = s_in;
    r  = '0;
    for (int i = 0; i < LW; i++) begin
      r[i] = d[i] ^ sr[38] ^ sr[57];
      sr   = {sr[56:0], r[i]};
    end
    s_out = sr;
  endfunction

  logic [57:0]      m_st [LN];
  logic [LN*LW-1:0] m_data;
  logic [LN*2-1:0]  m_head;

  typedef struct {
    logic [LN-1:0]    v;
    logic [LN*LW-1:0] d;
    logic [LN*2-1:0]  h;
  } exp_t;
  exp_t exp_q[$];

  task automatic step(input logic rst_n, input logic [LN-1:0] v, input logic [LN*LW-1:0] d,
                      input logic [LN*2-1:0] h, input logic byp, input logic sl,
                      input logic [57:0] sd);
    exp_t        e;
    logic [LW-1:0] r;
    logic [57:0]   sn;
    if (!rst_n) begin
      for (int k = 0; k < LN; k++) m_st[k] = '1;
      m_data = '0;
      m_head = '0;
      e.v    = '0;
    end else begin
      for (int k = 0; k < LN; k++) begin
        if (v[k]) begin
          scr_ref(m_st[k], d[k*LW +: LW], r, sn);
          m_data[k*LW +: LW] = byp ? d[k*LW +: LW] : r;
          m_head[k*2 +: 2]   = h[k*2 +: 2];
          if (!byp) m_st[k] = sn;
        end
      end
      if (sl) for (int k = 0; k < LN; k++) m_st[k] = sd;
      e.v = v;
    end
    e.d = m_data;
    e.h = m_head;
    exp_q.push_back(e);
    nreset      = rst_n;
    valid_i     = v;
    data_i      = d;
    head_i      = h;
    bypass_i    = byp;
    seed_load_i = sl;
    seed_i      = sd;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("valid_o", 128'(valid_o), 128'(e.v));
    check("data_o",  128'(data_o),  128'(e.d));
    check("head_o",  128'(head_o),  128'(e.h));
  endtask

  typedef struct {
    logic             rst_n;
    logic [LN-1:0]    v;
    logic [LN*LW-1:0] d;
    logic [LN*2-1:0]  h;
    logic             byp;
    logic             sl;
    logic [57:0]      sd;
    int               chk_lane;   // < 0: reference model only
    logic [LW-1:0]    exp_w;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, input logic [LN-1:0] v, input logic [LN*LW-1:0] d,
                              input logic [LN*2-1:0] h, input logic byp, input logic sl,
                              input logic [57:0] sd, input int cl, input logic [LW-1:0] ew);
    vec_t t;
    t.rst_n = rst_n; t.v = v; t.d = d; t.h = h; t.byp = byp; t.sl = sl; t.sd = sd;
    t.chk_lane = cl; t.exp_w = ew;
    return t;
  endfunction

  typedef struct {
    logic [65:0] d;
    logic [1:0]  h;
  } sb_t;
  sb_t sbq [CN*2][$];
  int  rx_cnt [CN*2];

  task automatic run_chain(input bit seeded, input int ncyc);
    sb_t          e;
    logic [131:0] mask, got;
    int           idx, skip;
    ch_valid = '0;
    ch_rx_sl = 1'b0;
    nreset   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    if (seeded) begin
      ch_rx_sl = 1'b1;
      @(posedge clk);
      #1;
      ch_rx_sl = 1'b0;
    end
    for (int i = 0; i < CN*2; i++) begin
      sbq[i].delete();
      rx_cnt[i] = 0;
    end
    for (int c = 0; c < ncyc + 3; c++) begin
      if (c < ncyc) begin
        ch_valid = 2'($urandom_range(0, 3));
        for (int b = 0; b < 132; b++) ch_data[b] = 1'($urandom_range(0, 1));
        ch_head = 4'($urandom);
      end else begin
        ch_valid = '0;
      end
      for (int g = 0; g < CN; g++) begin
        mask = (132'(1) << CL[g]) - 132'(1);
        for (int ln = 0; ln < 2; ln++) begin
          if (ch_valid[ln]) begin
            e.d = 66'((ch_data >> (ln*CL[g])) & mask);
            e.h = ch_head[ln*2 +: 2];
            sbq[g*2+ln].push_back(e);
          end
        end
      end
      @(posedge clk);
      #1;
      for (int g = 0; g < CN; g++) begin
        mask = (132'(1) << CL[g]) - 132'(1);
        skip = seeded ? (S_W + CL[g] - 1) / CL[g] : 0;
        for (int ln = 0; ln < 2; ln++) begin
          idx = g*2 + ln;
          if (ch_rx_valid[g][ln]) begin
            if (sbq[idx].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL chain_unexpected_beat: len %0d lane %0d got beat expected none", CL[g], ln);
            end else begin
              e   = sbq[idx].pop_front();
              got = (ch_rx_data[g] >> (ln*CL[g])) & mask;
              if (rx_cnt[idx] >= skip) check("chain_data", 128'(got), 128'(e.d));
              check("chain_head", 128'(ch_rx_head[g][ln*2 +: 2]), 128'(e.h));
              rx_cnt[idx]++;
            end
          end
        end
      end
    end
    for (int i = 0; i < CN*2; i++) check("chain_drain", 128'(sbq[i].size()), 128'(0));
  endtask

  vec_t vt[13];

  initial begin
    logic [LW-1:0] got;
    logic          rst_n, byp, sl;
    logic [LN*LW-1:0] rd;

    nreset = 1'b0; valid_i = '0; data_i = '0; head_i = '0;
    bypass_i = 1'b0; seed_load_i = 1'b0; seed_i = '0;
    ch_data = '0; ch_valid = '0; ch_head = '0; ch_rx_sl = 1'b0;

    vt[0]  = mk(1, 4'b0001, '0, 8'h01, 0, 0, '0, 0, 32'h00000000);
    vt[1]  = mk(1, 4'b0001, '0, 8'h02, 0, 0, '0, 0, 32'h03FFFF80);
    vt[2]  = mk(1, 4'b0010, '0, 8'h04, 0, 0, '0, 1, 32'h00000000);
    vt[3]  = mk(1, 4'b0010, '0, 8'h0C, 0, 0, '0, 1, 32'h03FFFF80);
    vt[4]  = mk(1, 4'b0001, 128'hDEADBEEF, 8'h03, 1, 0, '0, 0, 32'hDEADBEEF);
    vt[5]  = mk(1, 4'b0001, '0, 8'h01, 0, 0, '0, 0, 32'hFFFFC000);
    vt[6]  = mk(1, 4'b0001, 128'h12345678, 8'h02, 0, 1, '0, -1, '0);
    vt[7]  = mk(1, 4'b1001, '0, 8'h41, 0, 0, '0, 0, 32'h00000000);
    vt[8]  = mk(0, 4'b0001, 128'hAAAA5555, 8'h03, 0, 0, '0, 0, 32'h00000000);
    vt[9]  = mk(1, 4'b0001, '0, 8'h01, 0, 0, '0, 0, 32'h00000000);
    vt[10] = mk(1, 4'b0001, '0, 8'h02, 0, 0, '0, 0, 32'h03FFFF80);
    vt[11] = mk(1, 4'b0100, {32'h0, 32'h5A5A1234, 64'h0}, 8'h30, 1, 1, 58'h2A5_1234_5678_9ABC, 2, 32'h5A5A1234);
    vt[12] = mk(1, 4'b0100, '0, 8'h10, 0, 0, '0, -1, '0);

    step(0, '0, '0, '0, 0, 0, '0);
    step(0, '0, '0, '0, 0, 0, '0);

    for (int i = 0; i < 13; i++) begin
      step(vt[i].rst_n, vt[i].v, vt[i].d, vt[i].h, vt[i].byp, vt[i].sl, vt[i].sd);
      if (vt[i].chk_lane >= 0) begin
        got = data_o[vt[i].chk_lane*LW +: LW];
        check("lit_word", 128'(got), 128'(vt[i].exp_w));
      end
    end

    for (int c = 0; c < 80; c++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      byp   = ($urandom_range(0, 7) == 0);
      sl    = ($urandom_range(0, 15) == 0);
      for (int b = 0; b < LN*LW; b += 32) rd[b +: 32] = $urandom;
      step(rst_n, 4'($urandom), rd, 8'($urandom), byp, sl, 58'({$urandom, $urandom}));
    end

    run_chain(1'b0, 200);
    run_chain(1'b1, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
